// File: rtl/VX_dma_pkg.sv
// Shared DMA bus types: FSM state encoding, direction codes and descriptor payloads.
package VX_dma_pkg;

    localparam int unsigned DMA_ADDR_WIDTH = 32;
    localparam int unsigned DMA_SIZE_WIDTH = 16;
    localparam int unsigned DMA_TAG_WIDTH  = 8;

    localparam logic DMA_DIR_G2L = 1'b0;
    localparam logic DMA_DIR_L2G = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        RSP
    } dma_state_e;

    typedef struct packed {
        logic [DMA_ADDR_WIDTH-1:0] src_addr;
        logic [DMA_ADDR_WIDTH-1:0] dst_addr;
        logic [DMA_SIZE_WIDTH-1:0] size;
        logic                      direction;
        logic [DMA_TAG_WIDTH-1:0]  tag;
    } dma_req_t;

    typedef struct packed {
        logic [DMA_TAG_WIDTH-1:0] tag;
    } dma_rsp_t;

endpackage

// File: rtl/VX_dma_bus_if.sv
// DMA descriptor bus: request carries a copy descriptor, response returns its tag.
interface VX_dma_bus_if;
    import VX_dma_pkg::*;

    logic     req_valid;
    dma_req_t req_data;
    logic     req_ready;
    logic     rsp_valid;
    dma_rsp_t rsp_data;
    logic     rsp_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        input  rsp_ready
    );

endinterface

// File: rtl/vx_dma_engine.sv
// DMA responder: copies one descriptor at a time word by word between gmem and lmem.
// Optional VX_DMA_PERF_EN adds perf_xfers / perf_busy_cycles counters.
module vx_dma_engine
    import VX_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    VX_dma_bus_if.slave           dma_bus,
    output logic                  gmem_req_valid,
    output logic                  gmem_req_rw,
    output logic [ADDR_WIDTH-1:0] gmem_req_addr,
    output logic [DATA_WIDTH-1:0] gmem_req_data,
    input  logic                  gmem_req_ready,
    input  logic                  gmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] gmem_rsp_data,
    output logic                  gmem_rsp_ready,
    output logic                  lmem_req_valid,
    output logic                  lmem_req_rw,
    output logic [ADDR_WIDTH-1:0] lmem_req_addr,
    output logic [DATA_WIDTH-1:0] lmem_req_data,
    input  logic                  lmem_req_ready,
    input  logic                  lmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] lmem_rsp_data,
    output logic                  lmem_rsp_ready
`ifdef VX_DMA_PERF_EN
    ,
    output logic [31:0]           perf_xfers,
    output logic [31:0]           perf_busy_cycles
`endif
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BPW);
    localparam int unsigned CNT_W = 16;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BPW - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BPW);

    dma_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                  dir_q, dir_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    // Registered handshake outputs, computed from the next state
    logic req_ready_q, req_ready_d;
    logic rsp_valid_q, rsp_valid_d;
    logic g_req_valid_q, g_req_valid_d;
    logic l_req_valid_q, l_req_valid_d;
    logic g_rsp_ready_q, g_rsp_ready_d;
    logic l_rsp_ready_q, l_rsp_ready_d;

    logic                  src_req_ready_c;
    logic                  dst_req_ready_c;
    logic                  src_rsp_valid_c;
    logic [DATA_WIDTH-1:0] src_rsp_data_c;
    logic [CNT_W-1:0]      words_c;

    // Select source/destination port by direction
    always_comb begin
        src_req_ready_c = (dir_q == DMA_DIR_L2G) ? lmem_req_ready : gmem_req_ready;
        dst_req_ready_c = (dir_q == DMA_DIR_L2G) ? gmem_req_ready : lmem_req_ready;
        src_rsp_valid_c = (dir_q == DMA_DIR_L2G) ? lmem_rsp_valid : gmem_rsp_valid;
        src_rsp_data_c  = (dir_q == DMA_DIR_L2G) ? lmem_rsp_data  : gmem_rsp_data;
        words_c         = CNT_W'(dma_bus.req_data.size >> OFFS);
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dir_d   = dir_q;
        tag_d   = tag_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (dma_bus.req_valid && req_ready_q) begin
                    src_d   = ADDR_WIDTH'(dma_bus.req_data.src_addr) & ADDR_MASK;
                    dst_d   = ADDR_WIDTH'(dma_bus.req_data.dst_addr) & ADDR_MASK;
                    dir_d   = dma_bus.req_data.direction;
                    tag_d   = TAG_WIDTH'(dma_bus.req_data.tag);
                    cnt_d   = words_c;
                    state_d = (words_c == '0) ? RSP : RD_REQ;
                end
            end
            RD_REQ: begin
                if (src_req_ready_c) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (src_rsp_valid_c) begin
                    word_d  = src_rsp_data_c;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (dst_req_ready_c) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    src_d   = src_q + ADDR_STEP;
                    dst_d   = dst_q + ADDR_STEP;
                    state_d = (cnt_q == CNT_W'(1)) ? RSP : RD_REQ;
                end
            end
            RSP: begin
                if (dma_bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == RSP);
        g_req_valid_d = ((state_d == RD_REQ) && (dir_d == DMA_DIR_G2L))
                     || ((state_d == WR_REQ) && (dir_d == DMA_DIR_L2G));
        l_req_valid_d = ((state_d == RD_REQ) && (dir_d == DMA_DIR_L2G))
                     || ((state_d == WR_REQ) && (dir_d == DMA_DIR_G2L));
        g_rsp_ready_d = (state_d == RD_WAIT) && (dir_d == DMA_DIR_G2L);
        l_rsp_ready_d = (state_d == RD_WAIT) && (dir_d == DMA_DIR_L2G);
    end

    // State, descriptor and output registers; reset aborts any transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            dir_q         <= DMA_DIR_G2L;
            tag_q         <= '0;
            word_q        <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            g_req_valid_q <= 1'b0;
            l_req_valid_q <= 1'b0;
            g_rsp_ready_q <= 1'b0;
            l_rsp_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            dir_q         <= dir_d;
            tag_q         <= tag_d;
            word_q        <= word_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            g_req_valid_q <= g_req_valid_d;
            l_req_valid_q <= l_req_valid_d;
            g_rsp_ready_q <= g_rsp_ready_d;
            l_rsp_ready_q <= l_rsp_ready_d;
        end
    end

    assign dma_bus.req_ready = req_ready_q;
    assign dma_bus.rsp_valid = rsp_valid_q;
    assign dma_bus.rsp_data  = dma_rsp_t'(DMA_TAG_WIDTH'(tag_q));

    assign gmem_req_valid = g_req_valid_q;
    assign gmem_req_rw    = (dir_q == DMA_DIR_L2G);
    assign gmem_req_addr  = (dir_q == DMA_DIR_L2G) ? dst_q : src_q;
    assign gmem_req_data  = word_q;
    assign gmem_rsp_ready = g_rsp_ready_q;

    assign lmem_req_valid = l_req_valid_q;
    assign lmem_req_rw    = (dir_q == DMA_DIR_G2L);
    assign lmem_req_addr  = (dir_q == DMA_DIR_L2G) ? src_q : dst_q;
    assign lmem_req_data  = word_q;
    assign lmem_rsp_ready = l_rsp_ready_q;

`ifdef VX_DMA_PERF_EN
    logic [31:0] perf_xfers_q;
    logic [31:0] perf_busy_q;

    // Completed-transfer and busy-cycle counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_xfers_q <= '0;
            perf_busy_q  <= '0;
        end else begin
            if ((state_q == RSP) && dma_bus.rsp_ready) perf_xfers_q <= perf_xfers_q + 32'd1;
            if (state_q != IDLE) perf_busy_q <= perf_busy_q + 32'd1;
        end
    end

    assign perf_xfers       = perf_xfers_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_vx_dma_engine.sv
// Directed bench for vx_dma_engine with behavioural gmem/lmem responders.
module tb_vx_dma_engine;
    import VX_dma_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    VX_dma_bus_if dma_bus ();

    logic        gmem_req_valid, gmem_req_rw, gmem_req_ready, gmem_rsp_valid, gmem_rsp_ready;
    logic [31:0] gmem_req_addr;
    logic [63:0] gmem_req_data, gmem_rsp_data;
    logic        lmem_req_valid, lmem_req_rw, lmem_req_ready, lmem_rsp_valid, lmem_rsp_ready;
    logic [31:0] lmem_req_addr;
    logic [63:0] lmem_req_data, lmem_rsp_data;
`ifdef VX_DMA_PERF_EN
    logic [31:0] perf_xfers, perf_busy_cycles;
`endif

    vx_dma_engine dut (
        .clk            (clk),
        .reset          (reset),
        .dma_bus        (dma_bus),
        .gmem_req_valid (gmem_req_valid),
        .gmem_req_rw    (gmem_req_rw),
        .gmem_req_addr  (gmem_req_addr),
        .gmem_req_data  (gmem_req_data),
        .gmem_req_ready (gmem_req_ready),
        .gmem_rsp_valid (gmem_rsp_valid),
        .gmem_rsp_data  (gmem_rsp_data),
        .gmem_rsp_ready (gmem_rsp_ready),
        .lmem_req_valid (lmem_req_valid),
        .lmem_req_rw    (lmem_req_rw),
        .lmem_req_addr  (lmem_req_addr),
        .lmem_req_data  (lmem_req_data),
        .lmem_req_ready (lmem_req_ready),
        .lmem_rsp_valid (lmem_rsp_valid),
        .lmem_rsp_data  (lmem_rsp_data),
        .lmem_rsp_ready (lmem_rsp_ready)
`ifdef VX_DMA_PERF_EN
        ,
        .perf_xfers       (perf_xfers),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    localparam logic [1:0] K_GRD = 2'd0, K_LRD = 2'd1, K_GWR = 2'd2, K_LWR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] rspq[$];
    int acc_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
    int g_rdy_cnt = 0, l_rdy_cnt = 0;
    bit stall = 1'b0, hold_l = 1'b0;

    // Memory read data is a fixed function of the word address
    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {~a, a};
    endfunction

    bit          g_rd, l_rd, g_rsp_hs, l_rsp_hs;
    logic [31:0] g_rd_a, l_rd_a;
    bit          pend_g, pend_l, pend_r;
    logic [31:0] sv_ga, sv_la;
    logic [63:0] sv_gd, sv_ld;
    logic [7:0]  sv_tag;

    // Memory responders, bus monitor and hold-stability checks
    initial begin : responder
        gmem_req_ready = 1'b1; lmem_req_ready = 1'b1;
        gmem_rsp_valid = 1'b0; lmem_rsp_valid = 1'b0;
        gmem_rsp_data  = '0;   lmem_rsp_data  = '0;
        dma_bus.rsp_ready = 1'b1;
        pend_g = 0; pend_l = 0; pend_r = 0;
        forever begin
            @(negedge clk);
            g_rd = 0; l_rd = 0; g_rsp_hs = 0; l_rsp_hs = 0;
            if (!reset) begin
                if (pend_g) begin
                    check("g_hold_valid", 64'(gmem_req_valid), 64'd1);
                    check("g_hold_addr", 64'(gmem_req_addr), 64'(sv_ga));
                    check("g_hold_data", gmem_req_data, sv_gd);
                end
                if (pend_l) begin
                    check("l_hold_valid", 64'(lmem_req_valid), 64'd1);
                    check("l_hold_addr", 64'(lmem_req_addr), 64'(sv_la));
                    check("l_hold_data", lmem_req_data, sv_ld);
                end
                if (pend_r) begin
                    check("rsp_hold_valid", 64'(dma_bus.rsp_valid), 64'd1);
                    check("rsp_hold_tag", 64'(dma_bus.rsp_data.tag), 64'(sv_tag));
                end
                if (gmem_req_valid && gmem_req_ready) begin
                    evq.push_back('{kind: gmem_req_rw ? K_GWR : K_GRD, addr: gmem_req_addr,
                                    data: gmem_req_rw ? gmem_req_data : 64'd0});
                    if (!gmem_req_rw) begin g_rd = 1; g_rd_a = gmem_req_addr; end
                end
                if (lmem_req_valid && lmem_req_ready) begin
                    evq.push_back('{kind: lmem_req_rw ? K_LWR : K_LRD, addr: lmem_req_addr,
                                    data: lmem_req_rw ? lmem_req_data : 64'd0});
                    if (!lmem_req_rw) begin l_rd = 1; l_rd_a = lmem_req_addr; end
                end
                g_rsp_hs = gmem_rsp_valid && gmem_rsp_ready;
                l_rsp_hs = lmem_rsp_valid && lmem_rsp_ready;
                if (gmem_rsp_ready) g_rdy_cnt++;
                if (lmem_rsp_ready) l_rdy_cnt++;
                if (dma_bus.req_valid && dma_bus.req_ready) acc_cyc = cyc;
                if (dma_bus.rsp_valid && dma_bus.rsp_ready) begin
                    rspq.push_back(dma_bus.rsp_data.tag);
                    rsp_cyc = cyc;
                    rsp_cnt++;
                end
                pend_g = gmem_req_valid && !gmem_req_ready;
                pend_l = lmem_req_valid && !lmem_req_ready;
                pend_r = dma_bus.rsp_valid && !dma_bus.rsp_ready;
                sv_ga = gmem_req_addr; sv_gd = gmem_req_data;
                sv_la = lmem_req_addr; sv_ld = lmem_req_data;
                sv_tag = dma_bus.rsp_data.tag;
            end
            @(posedge clk);
            #1;
            if (reset) begin
                gmem_rsp_valid = 1'b0; lmem_rsp_valid = 1'b0;
                pend_g = 0; pend_l = 0; pend_r = 0;
            end else begin
                if (g_rsp_hs) gmem_rsp_valid = 1'b0;
                if (l_rsp_hs) lmem_rsp_valid = 1'b0;
                if (g_rd) begin gmem_rsp_valid = 1'b1; gmem_rsp_data = mdata(g_rd_a); end
                if (l_rd) begin lmem_rsp_valid = 1'b1; lmem_rsp_data = mdata(l_rd_a); end
            end
            gmem_req_ready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            lmem_req_ready    = hold_l ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            dma_bus.rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_desc(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] size,
                             input logic dir, input logic [7:0] tag, input string name);
        bit accepted = 0;
        @(posedge clk);
        #1;
        dma_bus.req_valid = 1'b1;
        dma_bus.req_data  = '{src_addr: src, dst_addr: dst, size: size, direction: dir, tag: tag};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dma_bus.req_ready) begin accepted = 1; break; end
        end
        check({name, "_accept"}, 64'(accepted), 64'd1);
        @(posedge clk);
        #1;
        dma_bus.req_valid = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] size,
                            input logic dir, input logic [7:0] tag, input string name);
        int start_cnt;
        bit done = 0;
        evq.delete(); rspq.delete();
        g_rdy_cnt = 0; l_rdy_cnt = 0;
        start_cnt = rsp_cnt;
        send_desc(src, dst, size, dir, tag, name);
        for (int i = 0; i < 3000; i++) begin
            if (rsp_cnt > start_cnt) begin done = 1; break; end
            @(negedge clk);
        end
        check({name, "_rsp_seen"}, 64'(done), 64'd1);
        check({name, "_rsp_tag"}, (rspq.size() > 0) ? 64'(rspq[0]) : 64'hDEAD, 64'(tag));
    endtask

    task automatic check_ev(input int idx, input logic [1:0] k, input logic [31:0] a,
                            input logic [63:0] d, input string name);
        if (idx < evq.size()) begin
            check({name, "_kind"}, 64'(evq[idx].kind), 64'(k));
            check({name, "_addr"}, 64'(evq[idx].addr), 64'(a));
            check({name, "_data"}, evq[idx].data, d);
        end else begin
            check({name, "_missing"}, 64'(evq.size()), 64'(idx + 1));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int start_cnt;
        bit found;
        dma_bus.req_valid = 1'b0;
        dma_bus.req_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(dma_bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(dma_bus.rsp_valid), 64'd0);
        check("rst_rsp_tag", 64'(dma_bus.rsp_data.tag), 64'd0);
        check("rst_g_valid", 64'(gmem_req_valid), 64'd0);
        check("rst_l_valid", 64'(lmem_req_valid), 64'd0);
        check("rst_g_rsp_ready", 64'(gmem_rsp_ready), 64'd0);
        check("rst_l_rsp_ready", 64'(lmem_rsp_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("req_ready_after_rst", 64'(dma_bus.req_ready), 64'd1);

        // Two-word G2L: reads and writes interleave word by word
        run_xfer(32'h1000, 32'h200, 16'd16, DMA_DIR_G2L, 8'h05, "g2l2");
        check("g2l2_latency", 64'(rsp_cyc - acc_cyc), 64'd7);
        check("g2l2_nev", 64'(evq.size()), 64'd4);
        check_ev(0, K_GRD, 32'h1000, 64'd0, "g2l2_e0");
        check_ev(1, K_LWR, 32'h200, 64'hFFFFEFFF_00001000, "g2l2_e1");
        check_ev(2, K_GRD, 32'h1008, 64'd0, "g2l2_e2");
        check_ev(3, K_LWR, 32'h208, 64'hFFFFEFF7_00001008, "g2l2_e3");
        check("g2l2_l_rsp_ready_idle", 64'(l_rdy_cnt), 64'd0);

        // Zero-size descriptor: immediate response, no memory traffic
        run_xfer(32'h40, 32'h80, 16'd0, DMA_DIR_L2G, 8'h0A, "zero");
        check("zero_latency", 64'(rsp_cyc - acc_cyc), 64'd1);
        check("zero_nev", 64'(evq.size()), 64'd0);

        // Size 12 gives one word; unaligned addresses are truncated
        run_xfer(32'h1003, 32'h305, 16'd12, DMA_DIR_G2L, 8'h03, "odd");
        check("odd_latency", 64'(rsp_cyc - acc_cyc), 64'd4);
        check("odd_nev", 64'(evq.size()), 64'd2);
        check_ev(0, K_GRD, 32'h1000, 64'd0, "odd_e0");
        check_ev(1, K_LWR, 32'h300, 64'hFFFFEFFF_00001000, "odd_e1");

        // L2G with destination wrapping past the top of the address space
        run_xfer(32'h50, 32'hFFFF_FFF8, 16'd16, DMA_DIR_L2G, 8'h77, "wrap");
        check("wrap_nev", 64'(evq.size()), 64'd4);
        check_ev(0, K_LRD, 32'h50, 64'd0, "wrap_e0");
        check_ev(1, K_GWR, 32'hFFFF_FFF8, 64'hFFFFFFAF_00000050, "wrap_e1");
        check_ev(2, K_LRD, 32'h58, 64'd0, "wrap_e2");
        check_ev(3, K_GWR, 32'h0, 64'hFFFFFFA7_00000058, "wrap_e3");
        check("wrap_g_rsp_ready_idle", 64'(g_rdy_cnt), 64'd0);

        // Random ready stalls on all handshakes
        stall = 1'b1;
        run_xfer(32'h2000, 32'h100, 16'd32, DMA_DIR_G2L, 8'h11, "stall");
        stall = 1'b0;
        repeat (20) @(negedge clk);
        check("stall_nrsp", 64'(rspq.size()), 64'd1);
        check("stall_nev", 64'(evq.size()), 64'd8);
        for (int i = 0; i < 4; i++) begin
            check_ev(2 * i, K_GRD, 32'h2000 + 32'(8 * i), 64'd0, "stall_rd");
            check_ev(2 * i + 1, K_LWR, 32'h100 + 32'(8 * i), mdata(32'h2000 + 32'(8 * i)), "stall_wr");
        end

        // Reset while a write is held in WR_REQ
        hold_l = 1'b1;
        start_cnt = rsp_cnt;
        send_desc(32'h3000, 32'h400, 16'd32, DMA_DIR_G2L, 8'h22, "abort");
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lmem_req_valid) begin found = 1; break; end
        end
        check("abort_reach_wr", 64'(found), 64'd1);
        evq.delete();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_g_valid", 64'(gmem_req_valid), 64'd0);
        check("abort_l_valid", 64'(lmem_req_valid), 64'd0);
        check("abort_rsp_valid", 64'(dma_bus.rsp_valid), 64'd0);
        check("abort_g_rsp_ready", 64'(gmem_rsp_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold_l = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_cnt - start_cnt), 64'd0);
        check("abort_no_traffic", 64'(evq.size()), 64'd0);

        run_xfer(32'h10, 32'h20, 16'd8, DMA_DIR_G2L, 8'h33, "post");
        check("post_latency", 64'(rsp_cyc - acc_cyc), 64'd4);
        check_ev(0, K_GRD, 32'h10, 64'd0, "post_e0");
        check_ev(1, K_LWR, 32'h20, 64'hFFFFFFEF_00000010, "post_e1");

`ifdef VX_DMA_PERF_EN
        // Counters restarted at the abort reset: 4 + 1 + 7 busy cycles
        run_xfer(32'h0, 32'h0, 16'd0, DMA_DIR_L2G, 8'h44, "perf0");
        run_xfer(32'h1000, 32'h200, 16'd16, DMA_DIR_G2L, 8'h55, "perf2");
        check("perf_xfers", 64'(perf_xfers), 64'd3);
        check("perf_busy", 64'(perf_busy_cycles), 64'd12);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
